seq_shift_unit: RTL and testbench
=================================

// Module: seq_shift_unit
// PURPOSE
//  Parametrised multi-cycle shifter for the RISC-V datapath. Serves SLL/SRL/SRA (immediate
//  scaling and ALU shift ops) and generalises the fixed shift-left-by-2 stage.
//  Takes an operand and a shift amount through a start/done handshake.
//  Shifts up to STEP bits per clock, trading latency for area.
// PARAMETERS
//  WIDTH    32  operand/result width in bits; power of 2, >= 8
//  STEP     1   max bits shifted per cycle; one of 1,2,4,8; STEP <= WIDTH/2
//  SHAMT_W  derived localparam = $clog2(WIDTH); not overridable
// PORTS
//  clock    in   1        single clock; all state changes on posedge clock
//  reset    in   1        asynchronous, active-high reset
//  start    in   1        request; sampled only while accepting (IDLE or DONE)
//  op       in   2        00 SLL, 01 SRL, 10 SRA, 11 ROTR/illegal (see CONFIGURATION)
//  operand  in   WIDTH    value to shift; captured on the accept edge
//  shamt    in   SHAMT_W  shift amount 0..WIDTH-1; captured on the accept edge
//  busy     out  1        high while in SHIFT
//  done     out  1        one-cycle pulse; result valid from this cycle
//  result   out  WIDTH    shifted value; held until the next accept edge
//  op_err   out  1        illegal op flag; valid with done, held with result
// BEHAVIOUR
//  - Reset (async assert, any state): state=IDLE, busy=0, done=0, result=0, op_err=0,
//    internal accumulator and remaining count cleared.
//  - FSM states: IDLE, SHIFT, DONE.
//    - IDLE/DONE, start=1: capture operand into acc, set rem=shamt, latch op.
//      Next state is SHIFT if shamt!=0, else DONE.
//    - IDLE/DONE, start=0: go to IDLE.
//    - SHIFT: each edge shifts acc by k=min(STEP,rem) and sets rem-=k.
//      Go to DONE when the new rem==0.
//    - SHIFT ignores start; no queuing.
//    - DONE lasts exactly one cycle.
//  - Latency: with n=ceil(shamt/STEP), accept at edge t gives done high in the cycle after
//    edge t+n. shamt=0 gives done in the cycle after edge t.
//  - Back-to-back: start during DONE is accepted on that edge; done stays 0 next cycle
//    unless the new shamt=0, in which case done stays high a second cycle.
//  - done and busy are never both high. result = acc at all times.
//  - Arithmetic:
//    - SLL and SRL fill with zeros.
//    - SRA fills with the operand MSB captured at accept.
//    - Per-step shift is exact for any k; the bit width never grows (truncate to WIDTH).
//  - Reset mid-SHIFT: operation aborted, no done pulse, result forced to 0.
//  - Operand/shamt changes after the accept edge have no effect.
// CONFIGURATION
//  - Macro SEQ_SHIFT_ROTATE_EN:
//    - Defined: op=11 is rotate-right by shamt, same stepping and latency as the other
//      ops; op_err is tied 0.
//    - Undefined: op=11 takes the shamt=0 path regardless of shamt, so result=operand and
//      done comes one cycle after accept, with op_err=1 alongside done. op_err clears on
//      the next accept.
// STRUCTURE
//  - Package seq_shift_pkg: typedef enum shift_op_e {OP_SLL,OP_SRL,OP_SRA,OP_ROTR};
//    typedef enum state_e {IDLE,SHIFT,DONE}; localparam STEP_LEGAL list, checked by an
//    elaboration assertion.
//  - Sub-module shift_step (combinational): acc, k (0..STEP), op, fill bit -> acc shifted
//    by k. Instantiated once; the FSM and counter stay in seq_shift_unit.
// TESTING
//  1 Reset: assert reset mid-SHIFT (SLL, shamt=20) -> busy, done, result, op_err all 0
//    immediately; no done afterwards.
//  2 STEP=1, SLL 0x0000_0003 shamt=2 -> done 2 cycles after accept, result 0x0000_000C.
//    shamt=0 -> done next cycle, result=operand.
//  3 STEP=4, SRA 0x8000_0000 shamt=31 -> n=8, busy for 8 cycles, result 0xFFFF_FFFF.
//    SRL same operand -> result 0x0000_0001.
//  4 Back-to-back: start held high through DONE with SLL 1 shamt=1 then SRL 0x10 shamt=4
//    (STEP=1) -> two done pulses, results 0x2 then 0x1.
//  5 start pulsed during SHIFT with a different operand -> ignored; result from the
//    original request.
//  6 op=11, operand 0x0000_0001, shamt=1:
//    with SEQ_SHIFT_ROTATE_EN -> result 0x8000_0000, op_err=0;
//    without -> result 0x0000_0001, op_err=1, done 1 cycle after accept.

Source files
------------

// File: rtl/seq_shift_pkg.sv
// Shared types and configuration checks for the sequential shifter.
// Rotate support is selected by the SEQ_SHIFT_ROTATE_EN macro in seq_shift_unit.
package seq_shift_pkg;

  typedef enum logic [1:0] {
    OP_SLL  = 2'b00,
    OP_SRL  = 2'b01,
    OP_SRA  = 2'b10,
    OP_ROTR = 2'b11
  } shift_op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_e;

  // Bit s is set when s is an allowed per-cycle step (1, 2, 4, 8).
  localparam logic [8:0] STEP_LEGAL = 9'b1_0001_0110;

  function automatic bit step_is_legal(input int step);
    logic [3:0] w_idx;
    w_idx = step[3:0];
    return (step >= 1 && step <= 8) ? STEP_LEGAL[w_idx] : 1'b0;
  endfunction

endpackage

// File: rtl/seq_shift_unit_shift_step.sv
// Combinational single-step shifter: shifts i_acc by i_k (0..STEP) using op and fill bit.
module shift_step
  import seq_shift_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0]   i_acc,
  input  logic [SHAMT_W-1:0] i_k,
  input  shift_op_e          i_op,
  input  logic               i_fill,
  output logic [WIDTH-1:0]   o_shifted
);

  logic [2*WIDTH-1:0] w_ext;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_ext     = '0;
    o_shifted = i_acc;
    case (i_op)
      OP_SLL: o_shifted = i_acc << i_k;
      OP_SRL: o_shifted = i_acc >> i_k;
      OP_SRA: begin
        // Sign fill comes from the captured MSB, not the current accumulator top bit.
        w_ext     = {{WIDTH{i_fill}}, i_acc} >> i_k;
        o_shifted = w_ext[WIDTH-1:0];
      end
      OP_ROTR: begin
        w_ext     = {i_acc, i_acc} >> i_k;
        o_shifted = w_ext[WIDTH-1:0];
      end
      default: o_shifted = i_acc;
    endcase
  end

endmodule

// File: rtl/seq_shift_unit.sv
// Multi-cycle SLL/SRL/SRA shifter, up to STEP bits per clock, start/done handshake.
// Define SEQ_SHIFT_ROTATE_EN to make op=11 a rotate-right; otherwise it is flagged illegal.
module seq_shift_unit
  import seq_shift_pkg::*;
#(
  parameter  int WIDTH   = 32,
  parameter  int STEP    = 1,
  localparam int SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [1:0]         op,
  input  logic [WIDTH-1:0]   operand,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   result,
  output logic               op_err
);

  if (!step_is_legal(STEP) || STEP > WIDTH / 2 || WIDTH < 8 ||
      (WIDTH & (WIDTH - 1)) != 0) begin : g_bad_cfg
    $error("seq_shift_unit: illegal WIDTH/STEP combination");
  end

  localparam logic [SHAMT_W-1:0] STEP_K = SHAMT_W'(STEP);

  state_e             r_state;
  logic [WIDTH-1:0]   r_acc;
  logic [SHAMT_W-1:0] r_rem;
  shift_op_e          r_op;
  logic               r_fill;
  logic               r_busy;
  logic               r_done;
  logic               r_op_err;

  shift_op_e          w_op_in;
  logic               w_illegal;
  logic [SHAMT_W-1:0] w_k;
  logic [SHAMT_W-1:0] w_rem_next;
  logic [WIDTH-1:0]   w_shifted;

  assign w_op_in = shift_op_e'(op);

`ifdef SEQ_SHIFT_ROTATE_EN
  assign w_illegal = 1'b0;
`else
  assign w_illegal = (w_op_in == OP_ROTR);
`endif

  assign w_k        = (r_rem > STEP_K) ? STEP_K : r_rem;
  assign w_rem_next = r_rem - w_k;

  shift_step #(
    .WIDTH   (WIDTH),
    .SHAMT_W (SHAMT_W)
  ) u_shift_step (
    .i_acc     (r_acc),
    .i_k       (w_k),
    .i_op      (r_op),
    .i_fill    (r_fill),
    .o_shifted (w_shifted)
  );

  // NOTE: all state uses non-blocking assignments and every register, including the
  // accumulator, is cleared by the asynchronous reset so an aborted shift leaves no residue.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state  <= IDLE;
      r_acc    <= '0;
      r_rem    <= '0;
      r_op     <= OP_SLL;
      r_fill   <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_op_err <= 1'b0;
    end else begin
      case (r_state)
        SHIFT: begin
          r_acc <= w_shifted;
          r_rem <= w_rem_next;
          if (w_rem_next == '0) begin
            r_state <= DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: begin
          if (start) begin
            r_acc    <= operand;
            r_op     <= w_op_in;
            r_fill   <= operand[WIDTH-1];
            r_op_err <= w_illegal;
            // Illegal ops reuse the zero-shift path so result equals the operand.
            if (w_illegal || shamt == '0) begin
              r_rem   <= '0;
              r_state <= DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_rem   <= shamt;
              r_state <= SHIFT;
              r_busy  <= 1'b1;
              r_done  <= 1'b0;
            end
          end else begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
          end
        end
      endcase
    end
  end

  assign busy   = r_busy;
  assign done   = r_done;
  assign result = r_acc;
  assign op_err = r_op_err;

endmodule

// File: tb/tb_seq_shift_unit.sv
// Self-checking bench for seq_shift_unit: STEP=1 and STEP=4 instances against a reference model.
// Honours SEQ_SHIFT_ROTATE_EN the same way the design does.
module tb_seq_shift_unit;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        s1, s4;
  logic [1:0]  op1, op4;
  logic [31:0] a1, a4;
  logic [4:0]  sh1, sh4;
  logic        b1, d1, e1, b4, d4, e4;
  logic [31:0] r1, r4;

  int n_vec = 0;
  int n_bad = 0;

  seq_shift_unit #(.WIDTH(32), .STEP(1)) u_dut1 (
    .clock(clk), .reset(rst), .start(s1), .op(op1), .operand(a1), .shamt(sh1),
    .busy(b1), .done(d1), .result(r1), .op_err(e1)
  );

  seq_shift_unit #(.WIDTH(32), .STEP(4)) u_dut4 (
    .clock(clk), .reset(rst), .start(s4), .op(op4), .operand(a4), .shamt(sh4),
    .busy(b4), .done(d4), .result(r4), .op_err(e4)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: whole-shift arithmetic straight from the operation definitions.
  function automatic logic [31:0] model_res(input logic [1:0] o, input logic [31:0] a,
                                            input int sh);
    logic [63:0] t;
    case (o)
      2'b00: return a << sh;
      2'b01: return a >> sh;
      2'b10: return $signed(a) >>> sh;
      default: begin
`ifdef SEQ_SHIFT_ROTATE_EN
        t = {a, a} >> sh;
        return t[31:0];
`else
        t = '0;
        return a;
`endif
      end
    endcase
  endfunction

  function automatic bit model_err(input logic [1:0] o);
`ifdef SEQ_SHIFT_ROTATE_EN
    return 1'b0;
`else
    return o == 2'b11;
`endif
  endfunction

  function automatic int model_lat(input logic [1:0] o, input int sh, input int step);
    if (model_err(o) || sh == 0) return 0;
    return (sh + step - 1) / step;
  endfunction

  task automatic drive(input int sel, input logic s, input logic [1:0] o,
                       input logic [31:0] a, input logic [4:0] sh);
    if (sel == 4) begin s4 = s; op4 = o; a4 = a; sh4 = sh; end
    else          begin s1 = s; op1 = o; a1 = a; sh1 = sh; end
  endtask

  // {busy, done, op_err, result}
  function automatic logic [34:0] obs(input int sel);
    return (sel == 4) ? {b4, d4, e4, r4} : {b1, d1, e1, r1};
  endfunction

  // Accept one request; while busy, scramble the inputs (optionally with start pulses).
  task automatic run_op(input string tag, input int sel, input logic [1:0] o,
                        input logic [31:0] a, input int sh, input bit noisy);
    int          n;
    logic [31:0] exp;
    logic [34:0] v;
    n   = model_lat(o, sh, sel);
    exp = model_res(o, a, sh);
    @(negedge clk);
    drive(sel, 1'b1, o, a, sh[4:0]);
    @(posedge clk); #1;
    for (int i = 0; i <= n; i++) begin
      if (i > 0) begin @(posedge clk); #1; end
      v = obs(sel);
      if (i < n) begin
        check($sformatf("%s busy c%0d", tag, i), {62'd0, v[34:33]}, 64'b10);
        drive(sel, noisy ? 1'($urandom_range(0, 1)) : 1'b0, 2'($urandom),
              $urandom, 5'($urandom));
      end else begin
        check($sformatf("%s status", tag), {61'd0, v[34:32]}, {61'd0, 2'b01, model_err(o)});
        check($sformatf("%s result", tag), {32'd0, v[31:0]}, {32'd0, exp});
        drive(sel, 1'b0, 2'($urandom), $urandom, 5'($urandom));
      end
    end
    @(posedge clk); #1;
    v = obs(sel);
    check($sformatf("%s done drop", tag), {63'd0, v[33]}, 64'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [34:0] v;
    bit          saw;
    rst = 1'b1;
    drive(1, 1'b0, 2'b00, 32'd0, 5'd0);
    drive(4, 1'b0, 2'b00, 32'd0, 5'd0);
    #1;
    check("reset dut1", {29'd0, obs(1)}, 64'd0);
    check("reset dut4", {29'd0, obs(4)}, 64'd0);
    @(negedge clk); rst = 1'b0;

    run_op("sll3x2", 1, 2'b00, 32'h0000_0003, 2, 1'b0);
    check("sll3x2 value", {32'd0, r1}, 64'h0000_000C);
    run_op("shamt0", 1, 2'b00, 32'h1234_5678, 0, 1'b0);
    run_op("sra31", 4, 2'b10, 32'h8000_0000, 31, 1'b0);
    check("sra31 value", {32'd0, r4}, 64'hFFFF_FFFF);
    run_op("srl31", 4, 2'b01, 32'h8000_0000, 31, 1'b0);
    check("srl31 value", {32'd0, r4}, 64'h0000_0001);
    run_op("sub_step", 4, 2'b00, 32'h0000_00F1, 3, 1'b0);
    run_op("ignore_start", 1, 2'b00, 32'h0000_0005, 10, 1'b1);
    run_op("op11", 1, 2'b11, 32'h0000_0001, 1, 1'b0);
`ifdef SEQ_SHIFT_ROTATE_EN
    check("op11 value", {32'd0, r1}, 64'h8000_0000);
`else
    check("op11 value", {32'd0, r1}, 64'h0000_0001);
`endif
    run_op("op11_clear", 1, 2'b00, 32'h0000_0001, 1, 1'b0);

    // Back-to-back: start held high through DONE.
    @(negedge clk);
    drive(1, 1'b1, 2'b00, 32'h1, 5'd1);
    @(posedge clk); #1;
    check("b2b first busy", {62'd0, b1, d1}, 64'b10);
    drive(1, 1'b1, 2'b01, 32'h10, 5'd4);
    @(posedge clk); #1;
    check("b2b first done", {29'd0, obs(1)}, {29'd0, 3'b010, 32'h2});
    @(posedge clk); #1;
    drive(1, 1'b0, 2'b00, 32'hDEAD_BEEF, 5'd7);
    check("b2b second accept", {62'd0, b1, d1}, 64'b10);
    for (int i = 1; i < 4; i++) begin
      @(posedge clk); #1;
      check($sformatf("b2b second busy c%0d", i), {62'd0, b1, d1}, 64'b10);
    end
    @(posedge clk); #1;
    check("b2b second done", {29'd0, obs(1)}, {29'd0, 3'b010, 32'h1});

    // Back-to-back with shamt=0: done stays high for a second cycle.
    @(negedge clk);
    drive(1, 1'b1, 2'b01, 32'h10, 5'd0);
    @(posedge clk); #1;
    drive(1, 1'b1, 2'b00, 32'h7, 5'd0);
    check("b2b zero first", {29'd0, obs(1)}, {29'd0, 3'b010, 32'h10});
    @(posedge clk); #1;
    drive(1, 1'b0, 2'b00, 32'h0, 5'd0);
    check("b2b zero second", {29'd0, obs(1)}, {29'd0, 3'b010, 32'h7});
    @(posedge clk); #1;
    check("b2b zero drop", {63'd0, d1}, 64'd0);

    // Reset in the middle of a long shift.
    @(negedge clk);
    drive(1, 1'b1, 2'b00, 32'h0000_ABCD, 5'd20);
    @(posedge clk); #1;
    drive(1, 1'b0, 2'b00, 32'h0, 5'd0);
    repeat (5) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    v = obs(1);
    check("reset midshift", {29'd0, v}, 64'd0);
    @(negedge clk); rst = 1'b0;
    saw = 1'b0;
    repeat (25) begin
      @(posedge clk); #1;
      if (d1 || b1) saw = 1'b1;
    end
    check("no done after reset", {63'd0, saw}, 64'd0);

    // Randomized requests against the model.
    for (int t = 0; t < 150; t++) begin
      run_op($sformatf("rnd%0d", t), ($urandom_range(0, 1) != 0) ? 4 : 1,
             2'($urandom), $urandom, int'($urandom_range(0, 31)),
             1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
